multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 109 ++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// Bank of NCH independent up-counting timers with per-channel modulus,
// periodic/one-shot mode, sticky rollover flags and a combined interrupt.
module multi_timer #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned WID        = 20,
  parameter int unsigned RST_PERIOD = 1000000,
  parameter int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               increment,
  input  logic               cfg_we,
  input  logic [CW-1:0]      cfg_ch,
  input  logic [WID-1:0]     cfg_period,
  input  logic               cfg_oneshot,
  input  logic [NCH-1:0]     start,
  input  logic [NCH-1:0]     stop,
  input  logic [NCH-1:0]     ack,
  output logic [NCH*WID-1:0] count,
  output logic [NCH-1:0]     rolling_over,
  output logic [NCH-1:0]     running,
  output logic [NCH-1:0]     pending,
  output logic               irq
);

  localparam logic [WID-1:0] RST_PERIOD_W = WID'(RST_PERIOD);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WID-1:0] cnt_q, cnt_d;
    logic [WID-1:0] per_q, per_d;
    logic [WID-1:0] term;
    logic           os_q, os_d;
    logic           run_q, run_d;
    logic           pend_q, pend_d;
    logic           cfg_hit;
    logic           roll;

    // Out-of-range channel numbers never match, so they are dropped here.
    assign cfg_hit = cfg_we && (cfg_ch == CW'(i));

    // Period 0 wraps to an all-ones terminal, giving a full 2^WID modulus.
    assign term = per_q - WID'(1);
    assign roll = run_q & increment & (cnt_q == term);

    // Next state: stop > start/cfg > rollover > increment for count and running.
    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      os_d   = os_q;
      run_d  = run_q;
      pend_d = pend_q;

      if (roll) begin
        pend_d = 1'b1;
      end else if (ack[i]) begin
        pend_d = 1'b0;
      end

      if (cfg_hit) begin
        per_d = cfg_period;
        os_d  = cfg_oneshot;
      end

      if (stop[i]) begin
        run_d = 1'b0;
        if (start[i] || cfg_hit) begin
          cnt_d = '0;
        end
      end else if (start[i] || cfg_hit) begin
        cnt_d = '0;
        if (start[i]) begin
          run_d = 1'b1;
        end
      end else if (roll) begin
        cnt_d = '0;
        if (os_q) begin
          run_d = 1'b0;
        end
      end else if (run_q && increment) begin
        cnt_d = cnt_q + WID'(1);
      end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        per_q  <= RST_PERIOD_W;
        os_q   <= 1'b0;
        run_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        os_q   <= os_d;
        run_q  <= run_d;
        pend_q <= pend_d;
      end
    end

    assign count[i*WID +: WID] = cnt_q;
    assign rolling_over[i]     = roll;
    assign running[i]          = run_q;
    assign pending[i]          = pend_q;
  end

  assign irq = |pending;

endmodule
